digit_serial_adder: RTL

Parametrised digit-serial adder that generalises the single-bit half/full adder selection into a WIDTH-bit operation. It processes DIGIT bits per clock with a registered carry and a start/done handshake. It is the area-efficient adder for multi-cycle datapaths where one result per WIDTH/DIGIT+1 cycles is sufficient. The ADDER parameter keeps the established half/full selection: carry-in ignored or used.

---
 rtl/digit_serial_adder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock, registered carry, start/done handshake.
// Optional signed-overflow output is built when SERIAL_ADD_OVF_EN is defined.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int ADDER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             seed;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             last;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
    end

    // Carry seed: half mode discards cin, full mode feeds it into digit 0.
    case (ADDER)
      0: begin : g_half
        logic unused_cin;
        assign unused_cin = cin;
        assign seed       = 1'b0;
      end
      1: begin : g_full
        assign seed = cin;
      end
      default: begin : g_bad_adder
        $error("digit_serial_adder: ADDER must be 0 or 1");
        assign seed = 1'b0;
      end
    endcase
  endgenerate

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    {dig_co, dig_sum} = {1'b0, a_reg[cnt*DIGIT +: DIGIT]}
                      + {1'b0, b_reg[cnt*DIGIT +: DIGIT]}
                      + {{DIGIT{1'b0}}, carry};
    last = (cnt == CW'(N - 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= seed;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // Only the digit being processed is overwritten; older sum digits stay put.
          s[cnt*DIGIT +: DIGIT] <= dig_sum;
          carry                 <= dig_co;
          cnt                   <= cnt + 1'b1;
          if (last) begin
            co    <= dig_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (dig_sum[DIGIT-1] != a_reg[WIDTH-1]);
`endif
            state <= DONE;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
